// File: rtl/vertical_count.sv
// Vertical timing stage: counts scan lines on line_end, tracks the vertical region,
// and drives vsync, vertical enable, frame_start and frame_count (VCOUNT_FRAME_COUNTER_EN).
module vertical_count #(
  parameter logic [10:0] SYNC_PULSE   = 11'd6,
  parameter logic [10:0] FRONT_PORCH  = 11'd29,
  parameter logic [10:0] VISIBLE_AREA = 11'd768,
  parameter logic [10:0] BACK_PORCH   = 11'd3,
  parameter logic [10:0] WHOLE_FRAME  = 11'd806
) (
  input  logic        slow_clock,
  input  logic        reset_n,
  input  logic        line_end,
  output logic [10:0] out_vertical_counter,
  output logic        vsync,
  output logic        enable_display_vertically,
  output logic [1:0]  out_region,
  output logic        frame_start,
  output logic [7:0]  frame_count
);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    FRONT   = 2'd1,
    VISIBLE = 2'd2,
    BACK    = 2'd3
  } region_t;

  localparam logic [10:0] VISIBLE_START = SYNC_PULSE + FRONT_PORCH;
  localparam logic [10:0] BACK_START    = VISIBLE_START + VISIBLE_AREA;
  localparam logic [10:0] LAST_LINE     = WHOLE_FRAME - 11'd1;

  region_t     state;
  region_t     next_state;
  logic [10:0] next_count;
  logic        wrap;

  // Transitions look at the count the line is about to become, so the region
  // lands on the same edge as the counter with no skew.
  // NOTE: every always_comb output is given a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    wrap       = (out_vertical_counter == LAST_LINE);
    next_count = wrap ? 11'd0 : out_vertical_counter + 11'd1;
    unique case (state)
      SYNC:    if (next_count == SYNC_PULSE)    next_state = FRONT;
      FRONT:   if (next_count == VISIBLE_START) next_state = VISIBLE;
      VISIBLE: if (next_count == BACK_START)    next_state = BACK;
      BACK:    if (wrap)                        next_state = SYNC;
      default: next_state = SYNC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge slow_clock or negedge reset_n) begin
    if (!reset_n) begin
      out_vertical_counter      <= 11'd0;
      state                     <= SYNC;
      vsync                     <= 1'b0;
      enable_display_vertically <= 1'b0;
      frame_start               <= 1'b0;
    end else begin
      frame_start <= line_end & wrap;
      if (line_end) begin
        out_vertical_counter      <= next_count;
        state                     <= next_state;
        vsync                     <= (next_state != SYNC);
        enable_display_vertically <= (next_state == VISIBLE);
      end
    end
  end

  assign out_region = state;

`ifdef VCOUNT_FRAME_COUNTER_EN
  always_ff @(posedge slow_clock or negedge reset_n) begin
    if (!reset_n)
      frame_count <= 8'd0;
    else if (line_end && wrap)
      frame_count <= frame_count + 8'd1;
  end
`else
  assign frame_count = 8'd0;
`endif

endmodule
